// File: rtl/demux_1x2_stream_buf.sv
// demux_1x2_stream_buf
//   Buffered 1-to-2 stream router. Each accepted input word goes into one of
//   two independent FIFOs, chosen by in_sel. Each FIFO drains through its own
//   valid/ready handshake, so a stalled consumer only blocks its own output.
//
// Parameters
//   DATA_W : data word width
//   DEPTH  : entries per output FIFO (power of two, >= 2)
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_sel/
//   in_data/in_ready     : input stream; in_sel picks out0 (0) or out1 (1)
//   outN_valid/outN_data/
//   outN_ready           : output streams; data reads 0 while the FIFO is empty
//   cnt0, cnt1           : words routed to each output
//   cnt_clr              : synchronous clear of cnt0/cnt1
//
// Build option
//   DEMUX_STREAM_CNT_EN : when defined, builds the per-output word counters.
//                         When undefined, cnt0/cnt1 are tied to 0 and cnt_clr
//                         is ignored.

module demux_1x2_stream_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out0_valid,
  output logic [DATA_W-1:0] out0_data,
  input  logic              out0_ready,
  output logic              out1_valid,
  output logic [DATA_W-1:0] out1_data,
  input  logic              out1_ready,
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1,
  input  logic              cnt_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem   [2][DEPTH];
  logic [AW-1:0]     wptr  [2];
  logic [AW-1:0]     rptr  [2];
  logic [AW:0]       count [2];

  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_ready;

  assign out_ready = {out1_ready, out0_ready};

  // in_ready depends only on in_sel and registered occupancy; a pop in the
  // same cycle does not open a full FIFO (no pass-through path).
  always_comb begin
    full     = '0;
    empty    = '0;
    push     = '0;
    pop      = '0;
    for (int f = 0; f < 2; f++) begin
      full[f]  = (count[f] == FULL_CNT);
      empty[f] = (count[f] == '0);
    end
    in_ready = ~full[in_sel];
    for (int f = 0; f < 2; f++) begin
      push[f] = in_valid && in_ready && (in_sel == f[0]);
      pop[f]  = !empty[f] && out_ready[f];
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < 2; f++) begin
        wptr[f]  <= '0;
        rptr[f]  <= '0;
        count[f] <= '0;
      end
    end else begin
      for (int f = 0; f < 2; f++) begin
        if (push[f]) wptr[f] <= wptr[f] + 1'b1;
        if (pop[f])  rptr[f] <= rptr[f] + 1'b1;
        case ({push[f], pop[f]})
          2'b10:   count[f] <= count[f] + 1'b1;
          2'b01:   count[f] <= count[f] - 1'b1;
          default: count[f] <= count[f];
        endcase
      end
    end
  end

  // Storage carries no reset; stale entries are never visible because the
  // output data is forced to 0 while a FIFO is empty.
  always_ff @(posedge clk) begin
    for (int f = 0; f < 2; f++) begin
      if (push[f]) mem[f][wptr[f]] <= in_data;
    end
  end

  always_comb begin
    out0_valid = !empty[0];
    out1_valid = !empty[1];
    out0_data  = empty[0] ? '0 : mem[0][rptr[0]];
    out1_data  = empty[1] ? '0 : mem[1][rptr[1]];
  end

`ifdef DEMUX_STREAM_CNT_EN
  logic [15:0] cnt_q [2];

  // Clear wins over a same-cycle increment; counters wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      for (int f = 0; f < 2; f++) begin
        if (cnt_clr)      cnt_q[f] <= '0;
        else if (push[f]) cnt_q[f] <= cnt_q[f] + 16'd1;
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_demux_1x2_stream_buf.sv
module tb_demux_1x2_stream_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_sel;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out0_valid, out1_valid;
  logic [7:0] out0_data, out1_data;
  logic       out0_ready, out1_ready;
  logic [15:0] cnt0, cnt1;
  logic       cnt_clr;

  int total = 0;
  int bad   = 0;
  int exp_c0 = 0;
  int exp_c1 = 0;

`ifdef DEMUX_STREAM_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  demux_1x2_stream_buf #(.DATA_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out0_ready (out0_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .cnt_clr    (cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_cnt0"}, {16'd0, cnt0}, CNT_EN ? 32'(exp_c0 & 16'hFFFF) : 32'd0);
    chk({tag, "_cnt1"}, {16'd0, cnt1}, CNT_EN ? 32'(exp_c1 & 16'hFFFF) : 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b1; out1_ready = 1'b1; cnt_clr = 1'b0;
    #1;
    // reset state
    chk("rst_v0", out0_valid, 0);
    chk("rst_v1", out1_valid, 0);
    chk("rst_d0", out0_data, 0);
    chk("rst_d1", out1_data, 0);
    chk("rst_rdy_s0", in_ready, 1);
    in_sel = 1'b1; #1;
    chk("rst_rdy_s1", in_ready, 1);
    chk_cnt("rst");
    step(); step();
    #2 rst_n = 1'b1;
    step();
    chk("idle_v0", out0_valid, 0);
    chk("idle_v1", out1_valid, 0);

    // route and latency
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA5;
    chk("route_rdy0", in_ready, 1);
    chk("route_nobypass", out0_valid, 0);
    step(); exp_c0++;
    in_sel = 1'b1; in_data = 8'h3C;
    chk("route_v0", out0_valid, 1);
    chk("route_d0", out0_data, 8'hA5);
    chk("route_v1_pre", out1_valid, 0);
    step(); exp_c1++;
    in_valid = 1'b0;
    chk("route_v1", out1_valid, 1);
    chk("route_d1", out1_data, 8'h3C);
    chk("route_v0_popped", out0_valid, 0);
    step();
    chk("route_v1_popped", out1_valid, 0);
    chk_cnt("route");

    // full FIFO1 with out1 stalled
    out1_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h10 + 8'(k);
      step(); exp_c1++;
    end
    in_valid = 1'b0; in_sel = 1'b1; #1;
    chk("full_rdy1", in_ready, 0);
    chk("full_head", out1_data, 8'h10);
    // other output still accepts
    out0_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h77; #1;
    chk("iso_rdy0", in_ready, 1);
    step(); exp_c0++;
    in_valid = 1'b0;
    chk("iso_v0", out0_valid, 1);
    chk("iso_d0", out0_data, 8'h77);
    // pop in the same cycle must not open the full FIFO
    in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h99; out1_ready = 1'b1; #1;
    chk("full_rdy_pop", in_ready, 0);
    step();
    in_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      chk("drain_v", out1_valid, 1);
      chk("drain_d", out1_data, 8'h10 + 8'(k));
      step();
    end
    chk("drain_empty", out1_valid, 0);
    out0_ready = 1'b1;
    step();
    chk("iso_v0_done", out0_valid, 0);
    chk_cnt("full");

    // simultaneous push/pop at count 2
    out0_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0;
    in_data = 8'h20; step();
    in_data = 8'h21; step();
    exp_c0 += 2;
    out0_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = 8'h22 + 8'(k); #1;
      chk("pp_rdy", in_ready, 1);
      chk("pp_d", out0_data, 8'h20 + 8'(k));
      step(); exp_c0++;
    end
    in_valid = 1'b0;
    chk("pp_tail0", out0_data, 8'h28);
    step();
    chk("pp_tail1", out0_data, 8'h29);
    step();
    chk("pp_empty", out0_valid, 0);
    chk_cnt("pp");

    // asynchronous reset with words in flight
    out0_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'h40 + 8'(k); step();
    end
    in_valid = 1'b0;
    chk("mid_v_pre", out0_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_v_rst", out0_valid, 0);
    chk("mid_d_rst", out0_data, 0);
    exp_c0 = 0; exp_c1 = 0;
    chk_cnt("mid");
    #3 rst_n = 1'b1;
    step();
    chk("mid_v_after", out0_valid, 0);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h55; step(); exp_c0++;
    in_valid = 1'b0;
    chk("mid_d_new", out0_data, 8'h55);
    out0_ready = 1'b1; step();
    chk("mid_empty_again", out0_valid, 0);
    chk_cnt("post");

    // clear has priority over a same-cycle push
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h01; cnt_clr = 1'b1;
    step();
    exp_c0 = 0; exp_c1 = 0;
    cnt_clr = 1'b0; in_valid = 1'b0;
    chk_cnt("clr");
    step();

`ifdef DEMUX_STREAM_CNT_EN
    // counter wrap: 65535 words, then one more
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h5A;
    repeat (65535) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("wrap_ffff", {16'd0, cnt0}, 32'h0000FFFF);
    in_valid = 1'b1; step();
    in_valid = 1'b0;
    chk("wrap_zero", {16'd0, cnt0}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_1x2_stream_buf.md
# demux_1x2_stream_buf

Buffered 1-to-2 stream router that sits directly downstream of the 1x2 demux stage. It takes a single valid/ready input stream with a per-word select bit and steers each accepted word into one of two independent output FIFOs. Each FIFO drains through its own valid/ready handshake. The block absorbs consumer stalls per output, so a stalled output 1 does not block traffic bound for output 0.

## Interface
Parameters:
- `DATA_W`, 8: width of each data word.
- `DEPTH`, 4: entries per output FIFO; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: input word present.
- `in_sel`  in  1: destination; 0 → out0, 1 → out1. Qualified by `in_valid`.
- `in_data`  in  DATA_W: input word.
- `in_ready`  out  1: combinational; equals NOT full of the FIFO addressed by `in_sel`.
- `out0_valid`, `out1_valid`  out  1: FIFO n non-empty.
- `out0_data`, `out1_data`  out  DATA_W: head word of FIFO n; 0 when empty.
- `out0_ready`, `out1_ready`  in  1: consumer accepts head word.
- `cnt0`, `cnt1`  out  16: words routed to each output (see Configuration).
- `cnt_clr`  in  1: synchronous clear of `cnt0`/`cnt1`.

## Operation
- Push: a word is accepted on a rising edge with `in_valid && in_ready`. It is written at the write pointer of FIFO[`in_sel`]. The other FIFO is untouched.
- Pop: FIFO n is popped on a rising edge with `outN_valid && outN_ready`. The read pointer advances.
- Each FIFO has:
  - write and read pointers, `log2(DEPTH)` bits each, wrapping modulo `DEPTH`;
  - an occupancy count of `log2(DEPTH)+1` bits, range 0..`DEPTH`.
- Full is count == `DEPTH`. Empty is count == 0.
- Simultaneous push and pop on the same FIFO: the count is unchanged and both pointers advance.
- Full FIFO:
  - `in_ready` stays 0 for that `in_sel` even if a pop happens in the same cycle. There is no pass-through.
  - A word for the other, non-full FIFO is still accepted.
- Empty FIFO: no bypass. A word pushed in cycle t is not visible at the output in cycle t.
- Ordering: words are strictly FIFO per output. There is no ordering guarantee between outputs.
- `in_valid` low: `in_sel` and `in_data` are don't-care and no state changes.
- Reset while words are in flight: all FIFO contents are discarded and pointers and counts return to 0.

## Timing
- Reset values:
  - `out0_valid` = `out1_valid` = 0.
  - `out0_data` = `out1_data` = 0.
  - `cnt0` = `cnt1` = 0.
  - All pointers and counts = 0.
  - `in_ready` = 1 for either `in_sel`.
- Latency: a word accepted at edge t appears on `outN_valid`/`outN_data` after edge t, i.e. in the next cycle (1-cycle latency).
- Throughput: 1 word per cycle in, and 1 word per cycle per output out.
- `outN_data` is read from storage at the read pointer. It is stable while `outN_valid` is high and `outN_ready` is low.
- `in_ready` is combinational from `in_sel` and registered occupancy. It has no combinational path from `outN_ready`.

## Configuration
- Macro: `DEMUX_STREAM_CNT_EN`.
- Defined:
  - `cnt0`/`cnt1` increment by 1 on each accepted word routed to that output.
  - Counters wrap from 0xFFFF to 0x0000.
  - `cnt_clr` zeroes both counters on the next edge and takes priority over a same-cycle increment, so the result is 0.
- Undefined:
  - The counter registers are not built.
  - `cnt0`/`cnt1` are driven to constant 0 and `cnt_clr` is ignored.
  - Routing and FIFO behaviour are identical in both builds.

## Test plan
- Reset (`rst_n`=0), then release with no input: both `outN_valid`=0, `in_ready`=1, counters 0.
- Route and latency: push `in_sel`=0 with 0xA5, then `in_sel`=1 with 0x3C, both outputs ready=1. Required:
  - `out0` shows 0xA5 one cycle after its accept;
  - `out1` shows 0x3C one cycle after its accept;
  - with `DEMUX_STREAM_CNT_EN`, `cnt0`=1 and `cnt1`=1.
- Full/isolation: `out1_ready`=0, push 4 words 0x10..0x13 to out1. Required:
  - `in_ready`=0 for `in_sel`=1;
  - a push of 0x77 to out0 is still accepted and appears on `out0`;
  - releasing `out1_ready` drains 0x10, 0x11, 0x12, 0x13 in order.
- Simultaneous push/pop: with FIFO0 at count 2, push and pop FIFO0 every cycle for 8 cycles. Required: count stays 2, pointers wrap, and data order is preserved.
- Reset mid-operation: load 3 words into FIFO0, assert `rst_n`=0 asynchronously mid-cycle. Required: `out0_valid` drops immediately, and after release FIFO0 is empty.
- Counter wrap and clear (`DEMUX_STREAM_CNT_EN` defined):
  - preset-by-traffic `cnt0` to 0xFFFF, push 1 word → `cnt0`=0x0000;
  - assert `cnt_clr` in the same cycle as a push → `cnt0`=0.
